// File: rtl/ctl_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ctl_fsm : multi-cycle control unit with valid/ready instruction intake
// Rev 1.0
// ---------------------------------------------------------------------------

package ctl_fsm_pkg;
    typedef logic [7:0] reg_t;
    typedef logic [1:0] alu_op_t;

    localparam alu_op_t ALU_OP_ADD = 2'd0;
    localparam alu_op_t ALU_OP_SUB = 2'd1;

    localparam logic [7:0] OPCODE_NOP  = 8'h00;
    localparam logic [7:0] OPCODE_HLT  = 8'h01;
    localparam logic [7:0] OPCODE_IMOV = 8'h02;
    localparam logic [7:0] OPCODE_IADD = 8'h03;
    localparam logic [7:0] OPCODE_ISUB = 8'h04;
    localparam logic [7:0] OPCODE_MOV  = 8'h05;
    localparam logic [7:0] OPCODE_JMP  = 8'h06;

    // Power-up contract bit: 1 = halt on undefined opcode, 0 = request reset
    localparam int PUC_EOH = 0;
endpackage

module ctl_fsm
    import ctl_fsm_pkg::*;
#(
    parameter int                  WORD_LEN     = 64,
    parameter int                  N_PUC        = 2,
    parameter int                  PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned         PC_STEP      = 4
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                inst_valid_i,
    output logic                inst_ready_o,
    input  logic [31:0]         inst_i,
    output reg_t                reg_rd_id_o,
    input  logic [WORD_LEN-1:0] reg_value_i,
    input  logic [WORD_LEN-1:0] alu_op_res_i,
    input  logic [N_PUC-1:0]    puc_i,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic                reg_write_en_o,
    output reg_t                reg_id_o,
    output logic [WORD_LEN-1:0] reg_value_o,
    output logic [WORD_LEN-1:0] alu_op_a_o,
    output logic [WORD_LEN-1:0] alu_op_b_o,
    output alu_op_t             alu_opc_o,
    output logic                halted_o,
    output logic                reset_o
);

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_HALT   = 3'd3;
    localparam logic [2:0] ST_FAULT  = 3'd4;

    logic [2:0]          state_q,   state_d;
    logic [PC_WIDTH-1:0] pc_q,      pc_d;
    logic [31:0]         inst_q,    inst_d;
    logic                we_q,      we_d;
    reg_t                rid_q,     rid_d;
    logic [WORD_LEN-1:0] rval_q,    rval_d;
    logic [WORD_LEN-1:0] opa_q,     opa_d;
    logic [WORD_LEN-1:0] opb_q,     opb_d;
    alu_op_t             opc_q,     opc_d;
    logic                rstreq_q,  rstreq_d;

    logic [7:0]          w_opcode;
    reg_t                w_rd;
    reg_t                w_rs;
    logic [WORD_LEN-1:0] w_imm;
    logic [25:0]         w_jmp_tgt;
    logic                w_unused_puc;

    assign w_opcode     = inst_q[7:0];
    assign w_rd         = inst_q[15:8];
    assign w_rs         = inst_q[23:16];
    assign w_imm        = WORD_LEN'(inst_q[31:16]);
    assign w_jmp_tgt    = {inst_q[31:8], 2'b00};
    assign w_unused_puc = ^puc_i;

    // Register read port tracks the latched instruction so DECODE sees data same-cycle
    assign reg_rd_id_o = (w_opcode == OPCODE_MOV) ? w_rs : w_rd;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        we_d     = we_q;
        rid_d    = rid_q;
        rval_d   = rval_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        opc_d    = opc_q;
        rstreq_d = rstreq_q;

        case (state_q)
            ST_FETCH: begin
                we_d = 1'b0;
                if (inst_valid_i) begin
                    inst_d  = inst_i;
                    pc_d    = pc_q + PC_WIDTH'(PC_STEP);
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                case (w_opcode)
                    OPCODE_NOP: state_d = ST_FETCH;
                    OPCODE_HLT: state_d = ST_HALT;
                    OPCODE_IMOV: begin
                        rid_d   = w_rd;
                        rval_d  = w_imm;
                        we_d    = 1'b1;
                        state_d = ST_FETCH;
                    end
                    OPCODE_MOV: begin
                        rid_d   = w_rd;
                        rval_d  = reg_value_i;
                        we_d    = 1'b1;
                        state_d = ST_FETCH;
                    end
                    OPCODE_IADD, OPCODE_ISUB: begin
                        opa_d   = reg_value_i;
                        opb_d   = w_imm;
                        opc_d   = (w_opcode == OPCODE_ISUB) ? ALU_OP_SUB : ALU_OP_ADD;
                        rid_d   = w_rd;
                        state_d = ST_EXEC;
                    end
                    OPCODE_JMP: begin
                        pc_d    = PC_WIDTH'(w_jmp_tgt);
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_FAULT;
                endcase
            end

            ST_EXEC: begin
                rval_d  = alu_op_res_i;
                we_d    = 1'b1;
                state_d = ST_FETCH;
            end

            ST_FAULT: begin
                if (!puc_i[PUC_EOH]) begin
                    rstreq_d = 1'b1;
                end else begin
                    state_d = ST_HALT;
                end
            end

            ST_HALT: state_d = ST_HALT;

            default: state_d = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_VECTOR;
            inst_q   <= {24'h0, OPCODE_NOP};
            we_q     <= 1'b0;
            rid_q    <= '0;
            rval_q   <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            opc_q    <= ALU_OP_ADD;
            rstreq_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            we_q     <= we_d;
            rid_q    <= rid_d;
            rval_q   <= rval_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            opc_q    <= opc_d;
            rstreq_q <= rstreq_d;
        end
    end

    assign inst_ready_o   = (state_q == ST_FETCH);
    assign halted_o       = (state_q == ST_HALT);
    assign pc_o           = pc_q;
    assign reg_write_en_o = we_q;
    assign reg_id_o       = rid_q;
    assign reg_value_o    = rval_q;
    assign alu_op_a_o     = opa_q;
    assign alu_op_b_o     = opb_q;
    assign alu_opc_o      = opc_q;
    assign reset_o        = rstreq_q;

endmodule

`default_nettype wire

// File: tb/tb_ctl_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ctl_fsm : randomized, model-checked bench for ctl_fsm
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_ctl_fsm;
    import ctl_fsm_pkg::*;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        inst_valid_i;
    logic [31:0] inst_i;
    logic [1:0]  puc_i;

    logic        inst_ready_o, reg_write_en_o, halted_o, reset_o;
    reg_t        reg_rd_id_o, reg_id_o;
    logic [63:0] reg_value_i, alu_op_res_i, reg_value_o, alu_op_a_o, alu_op_b_o;
    logic [31:0] pc_o;
    alu_op_t     alu_opc_o;

    logic        u2_ready, u2_we, u2_halted, u2_reset;
    reg_t        u2_rd_id, u2_id;
    logic [63:0] u2_val, u2_a, u2_b;
    logic [31:0] u2_pc;
    alu_op_t     u2_opc;

    logic [63:0] rf   [256] = '{default: 64'h0};
    logic [63:0] m_rf [256];
    logic [31:0] m_pc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign reg_value_i  = rf[reg_rd_id_o];
    assign alu_op_res_i = (alu_opc_o == ALU_OP_SUB) ? alu_op_a_o - alu_op_b_o
                                                    : alu_op_a_o + alu_op_b_o;
    always @(posedge clk) if (reg_write_en_o) rf[reg_id_o] <= reg_value_o;

    ctl_fsm dut (
        .clk_i(clk), .reset_ni(reset_ni), .inst_valid_i(inst_valid_i),
        .inst_ready_o(inst_ready_o), .inst_i(inst_i), .reg_rd_id_o(reg_rd_id_o),
        .reg_value_i(reg_value_i), .alu_op_res_i(alu_op_res_i), .puc_i(puc_i),
        .pc_o(pc_o), .reg_write_en_o(reg_write_en_o), .reg_id_o(reg_id_o),
        .reg_value_o(reg_value_o), .alu_op_a_o(alu_op_a_o), .alu_op_b_o(alu_op_b_o),
        .alu_opc_o(alu_opc_o), .halted_o(halted_o), .reset_o(reset_o)
    );

    // Second instance parked just below the top of the address space for PC wrap
    ctl_fsm #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_wrap (
        .clk_i(clk), .reset_ni(reset_ni), .inst_valid_i(inst_valid_i),
        .inst_ready_o(u2_ready), .inst_i(inst_i), .reg_rd_id_o(u2_rd_id),
        .reg_value_i(64'h0), .alu_op_res_i(64'h0), .puc_i(puc_i),
        .pc_o(u2_pc), .reg_write_en_o(u2_we), .reg_id_o(u2_id),
        .reg_value_o(u2_val), .alu_op_a_o(u2_a), .alu_op_b_o(u2_b),
        .alu_opc_o(u2_opc), .halted_o(u2_halted), .reset_o(u2_reset)
    );

    // Architectural effect of one instruction: expected write, busy cycles, new PC
    task automatic model_step(input logic [31:0] ins, output logic e_we,
                              output logic [7:0] e_id, output logic [63:0] e_val,
                              output int e_busy);
        logic [7:0]  rd  = ins[15:8];
        logic [7:0]  rs  = ins[23:16];
        logic [63:0] imm = {48'h0, ins[31:16]};
        e_we = 1'b0; e_id = 8'h0; e_val = 64'h0; e_busy = 1;
        m_pc = m_pc + 32'd4;
        case (ins[7:0])
            OPCODE_IMOV: begin e_we = 1'b1; e_id = rd; e_val = imm; end
            OPCODE_MOV:  begin e_we = 1'b1; e_id = rd; e_val = m_rf[rs]; end
            OPCODE_IADD: begin e_we = 1'b1; e_id = rd; e_val = m_rf[rd] + imm; e_busy = 2; end
            OPCODE_ISUB: begin e_we = 1'b1; e_id = rd; e_val = m_rf[rd] - imm; e_busy = 2; end
            OPCODE_JMP:  m_pc = {6'b0, ins[31:8], 2'b00};
            default: ;
        endcase
        if (e_we) m_rf[e_id] = e_val;
    endtask

    task automatic run_inst(input logic [31:0] ins, output logic ok, output int nstb,
                            output logic [7:0] o_id, output logic [63:0] o_val,
                            output int busy, output alu_op_t o_opc);
        int k;
        ok = 1'b0; nstb = 0; o_id = 8'h0; o_val = 64'h0; busy = 0; o_opc = ALU_OP_ADD;
        inst_i = ins; inst_valid_i = 1'b1;
        k = 0;
        while (!inst_ready_o && k < 20) begin @(posedge clk); #1; k++; end
        if (!inst_ready_o) begin inst_valid_i = 1'b0; return; end
        @(posedge clk); #1;
        inst_valid_i = 1'b0;
        k = 0;
        while (!inst_ready_o && k < 10) begin
            busy++;
            o_opc = alu_opc_o;
            if (reg_write_en_o) nstb++;
            @(posedge clk); #1; k++;
        end
        if (!inst_ready_o) return;
        ok = 1'b1;
        if (reg_write_en_o) begin nstb++; o_id = reg_id_o; o_val = reg_value_o; end
    endtask

    task automatic do_reset();
        inst_valid_i = 1'b0;
        reset_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_ni = 1'b1;
        m_pc = 32'h0;
    endtask

    task automatic test_reset();
        reset_ni = 1'b1; inst_valid_i = 1'b0; inst_i = 32'h0; puc_i = 2'b00;
        #2 reset_ni = 1'b0;
        #1;
        n_tests++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", pc_o); end
        n_tests++; if ({inst_ready_o, halted_o, reset_o, reg_write_en_o} !== 4'b1000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 1000", {inst_ready_o, halted_o, reset_o, reg_write_en_o}); end
        n_tests++; if ({reg_id_o, reg_value_o, alu_op_a_o, alu_op_b_o, reg_rd_id_o} !== '0) begin
            n_fail++; $display("FAIL reset_data: id %h val %h a %h b %h rd %h expected all 0", reg_id_o, reg_value_o, alu_op_a_o, alu_op_b_o, reg_rd_id_o); end
        n_tests++; if (alu_opc_o !== ALU_OP_ADD) begin n_fail++; $display("FAIL reset_opc: got %0d expected %0d", alu_opc_o, ALU_OP_ADD); end
        @(posedge clk); @(posedge clk);
        #1 reset_ni = 1'b1;
        m_pc = 32'h0;
    endtask

    task automatic test_imov();
        logic ok; int n, busy, eb; logic [7:0] id, eid; logic [63:0] v, ev; alu_op_t opc; logic ew;
        model_step({16'h1234, 8'd1, OPCODE_IMOV}, ew, eid, ev, eb);
        run_inst({16'h1234, 8'd1, OPCODE_IMOV}, ok, n, id, v, busy, opc);
        n_tests++; if (!ok || n != 1 || id !== eid || v !== ev || busy != eb) begin n_fail++;
            $display("FAIL imov1: ok %b strobes %0d (%h,%h) busy %0d expected 1 strobe (%h,%h) busy %0d", ok, n, id, v, busy, eid, ev, eb); end
        model_step({16'hFFFF, 8'd2, OPCODE_IMOV}, ew, eid, ev, eb);
        run_inst({16'hFFFF, 8'd2, OPCODE_IMOV}, ok, n, id, v, busy, opc);
        n_tests++; if (!ok || n != 1 || id !== eid || v !== ev || busy != eb) begin n_fail++;
            $display("FAIL imov2: ok %b strobes %0d (%h,%h) busy %0d expected 1 strobe (%h,%h) busy %0d", ok, n, id, v, busy, eid, ev, eb); end
        n_tests++; if (pc_o !== 32'd8) begin n_fail++; $display("FAIL imov_pc: got %h expected 8", pc_o); end
        @(posedge clk); #1;
        n_tests++; if (reg_write_en_o !== 1'b0) begin n_fail++; $display("FAIL strobe_width: got %b expected 0", reg_write_en_o); end
    endtask

    task automatic test_arith();
        logic ok; int n, busy, eb; logic [7:0] id, eid; logic [63:0] v, ev; alu_op_t opc; logic ew;
        logic [31:0] seq [4];
        alu_op_t     eop [4];
        seq[0] = {16'h0, 8'd3, OPCODE_IMOV}; eop[0] = ALU_OP_ADD;
        seq[1] = {16'h1, 8'd3, OPCODE_ISUB}; eop[1] = ALU_OP_SUB;
        seq[2] = {16'h1, 8'd3, OPCODE_IADD}; eop[2] = ALU_OP_ADD;
        seq[3] = {16'h1, 8'd3, OPCODE_ISUB}; eop[3] = ALU_OP_SUB;
        for (int i = 0; i < 4; i++) begin
            model_step(seq[i], ew, eid, ev, eb);
            run_inst(seq[i], ok, n, id, v, busy, opc);
            n_tests++; if (!ok || n != 1 || id !== eid || v !== ev || busy != eb) begin n_fail++;
                $display("FAIL arith%0d: ok %b strobes %0d (%h,%h) busy %0d expected (%h,%h) busy %0d", i, ok, n, id, v, busy, eid, ev, eb); end
            if (i > 0) begin
                n_tests++; if (opc !== eop[i]) begin n_fail++; $display("FAIL arith_opc%0d: got %0d expected %0d", i, opc, eop[i]); end
            end
        end
    endtask

    task automatic test_hazard();
        logic ok; int n, busy, eb; logic [7:0] id, eid; logic [63:0] v, ev; alu_op_t opc; logic ew;
        logic [31:0] seq [3];
        seq[0] = {16'h5, 8'd4, OPCODE_IMOV};
        seq[1] = {16'h3, 8'd4, OPCODE_IADD};
        seq[2] = {8'h0, 8'd4, 8'd5, OPCODE_MOV};
        for (int i = 0; i < 3; i++) begin
            model_step(seq[i], ew, eid, ev, eb);
            run_inst(seq[i], ok, n, id, v, busy, opc);
            n_tests++; if (!ok || n != 1 || id !== eid || v !== ev) begin n_fail++;
                $display("FAIL hazard%0d: ok %b strobes %0d (%h,%h) expected (%h,%h)", i, ok, n, id, v, eid, ev); end
        end
    endtask

    task automatic test_jmp();
        logic ok; int n, busy, eb; logic [7:0] id, eid; logic [63:0] v, ev; alu_op_t opc; logic ew;
        model_step({24'h40, OPCODE_JMP}, ew, eid, ev, eb);
        run_inst({24'h40, OPCODE_JMP}, ok, n, id, v, busy, opc);
        n_tests++; if (!ok || pc_o !== 32'h100 || n != 0) begin n_fail++;
            $display("FAIL jmp: ok %b pc %h strobes %0d expected pc 100 strobes 0", ok, pc_o, n); end
        model_step({24'h0, OPCODE_NOP}, ew, eid, ev, eb);
        run_inst({24'h0, OPCODE_NOP}, ok, n, id, v, busy, opc);
        n_tests++; if (!ok || pc_o !== m_pc) begin n_fail++; $display("FAIL jmp_next: pc %h expected %h", pc_o, m_pc); end
    endtask

    task automatic test_pc_wrap();
        logic ok; int n, busy; logic [7:0] id; logic [63:0] v; alu_op_t opc;
        do_reset();
        n_tests++; if (u2_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_rv: got %h expected fffffffc", u2_pc); end
        run_inst({24'h0, OPCODE_NOP}, ok, n, id, v, busy, opc);
        m_pc = m_pc + 32'd4;
        n_tests++; if (!ok || u2_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h expected 0", u2_pc); end
    endtask

    task automatic test_stall();
        logic [31:0] p = pc_o;
        inst_valid_i = 1'b0;
        inst_i = {16'h7, 8'd9, OPCODE_IMOV};
        repeat (6) @(posedge clk);
        #1;
        n_tests++; if (pc_o !== p || inst_ready_o !== 1'b1 || reg_write_en_o !== 1'b0) begin n_fail++;
            $display("FAIL stall: pc %h ready %b we %b expected pc %h ready 1 we 0", pc_o, inst_ready_o, reg_write_en_o, p); end
    endtask

    task automatic test_random();
        logic ok; int n, busy, eb; logic [7:0] id, eid; logic [63:0] v, ev; alu_op_t opc; logic ew;
        logic [7:0] ops [6];
        logic [31:0] ins;
        ops[0] = OPCODE_NOP; ops[1] = OPCODE_IMOV; ops[2] = OPCODE_MOV;
        ops[3] = OPCODE_IADD; ops[4] = OPCODE_ISUB; ops[5] = OPCODE_JMP;
        for (int i = 0; i < 60; i++) begin
            ins = {$urandom_range(0, 65535), 8'($urandom_range(0, 7)), ops[$urandom_range(0, 5)]};
            if (ins[7:0] == OPCODE_MOV) ins[23:16] = 8'($urandom_range(0, 7));
            model_step(ins, ew, eid, ev, eb);
            run_inst(ins, ok, n, id, v, busy, opc);
            n_tests++; if (!ok || n != int'(ew) || busy != eb || (ew && (id !== eid || v !== ev))) begin n_fail++;
                $display("FAIL rand%0d inst %h: ok %b strobes %0d (%h,%h) busy %0d expected %0d (%h,%h) busy %0d", i, ins, ok, n, id, v, busy, ew, eid, ev, eb); end
            n_tests++; if (pc_o !== m_pc) begin n_fail++; $display("FAIL rand_pc%0d: got %h expected %h", i, pc_o, m_pc); end
        end
    endtask

    task automatic test_fault();
        logic ok; int n, busy; logic [7:0] id; logic [63:0] v; alu_op_t opc;
        do_reset();
        puc_i = 2'b00;
        run_inst(32'h0000_00EE, ok, n, id, v, busy, opc);
        n_tests++; if (ok || reset_o !== 1'b1 || inst_ready_o !== 1'b0 || halted_o !== 1'b0) begin n_fail++;
            $display("FAIL fault_rst: ok %b reset_o %b ready %b halted %b expected 0 1 0 0", ok, reset_o, inst_ready_o, halted_o); end
        puc_i = 2'b01;
        repeat (5) @(posedge clk);
        #1;
        n_tests++; if (reset_o !== 1'b1) begin n_fail++; $display("FAIL fault_sticky: got %b expected 1", reset_o); end
        do_reset();
        n_tests++; if (reset_o !== 1'b0) begin n_fail++; $display("FAIL fault_clear: got %b expected 0", reset_o); end
        run_inst(32'h0000_00EE, ok, n, id, v, busy, opc);
        inst_i = {16'h1, 8'd1, OPCODE_IMOV}; inst_valid_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_tests++; if (halted_o !== 1'b1 || reset_o !== 1'b0 || pc_o !== 32'd4 || inst_ready_o !== 1'b0) begin n_fail++;
            $display("FAIL fault_halt: halted %b reset_o %b pc %h ready %b expected 1 0 4 0", halted_o, reset_o, pc_o, inst_ready_o); end
        inst_valid_i = 1'b0;
        puc_i = 2'b00;
    endtask

    task automatic test_reset_mid();
        logic ok; int n, busy, eb; logic [7:0] id, eid; logic [63:0] v, ev; alu_op_t opc; logic ew;
        do_reset();
        model_step({16'h7, 8'd6, OPCODE_IMOV}, ew, eid, ev, eb);
        run_inst({16'h7, 8'd6, OPCODE_IMOV}, ok, n, id, v, busy, opc);
        inst_i = {16'h9, 8'd6, OPCODE_IADD}; inst_valid_i = 1'b1;
        @(posedge clk); #1 inst_valid_i = 1'b0;
        @(posedge clk); #1;
        reset_ni = 1'b0;
        #1;
        n_tests++; if (reg_write_en_o !== 1'b0 || pc_o !== 32'h0 || inst_ready_o !== 1'b1 || alu_opc_o !== ALU_OP_ADD) begin n_fail++;
            $display("FAIL rstmid_ctl: we %b pc %h ready %b opc %0d expected 0 0 1 0", reg_write_en_o, pc_o, inst_ready_o, alu_opc_o); end
        n_tests++; if ({reg_id_o, reg_value_o, alu_op_a_o, alu_op_b_o, halted_o, reset_o} !== '0) begin n_fail++;
            $display("FAIL rstmid_data: id %h val %h a %h b %h expected all 0", reg_id_o, reg_value_o, alu_op_a_o, alu_op_b_o); end
        @(posedge clk); #1 reset_ni = 1'b1;
        m_pc = 32'h0;
        n_tests++; if (rf[6] !== m_rf[6]) begin n_fail++; $display("FAIL rstmid_nowrite: r6 %h expected %h", rf[6], m_rf[6]); end
        n_tests++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_pc: got %h expected 0", pc_o); end
        model_step({24'h0, OPCODE_NOP}, ew, eid, ev, eb);
        run_inst({24'h0, OPCODE_NOP}, ok, n, id, v, busy, opc);
        n_tests++; if (!ok || pc_o !== m_pc) begin n_fail++; $display("FAIL rstmid_fetch: pc %h expected %h", pc_o, m_pc); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_rf[i] = 64'h0;
        m_pc = 32'h0;
        test_reset();
        test_imov();
        test_arith();
        test_hazard();
        test_jmp();
        test_stall();
        test_random();
        test_pc_wrap();
        test_fault();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctl_fsm.md
# ctl_fsm

Parametrised multi-cycle control unit succeeding the single-stage on-core controller. It sits between the fetch unit, register file and ALU, and accepts instructions over a valid/ready handshake. Each instruction is sequenced through an explicit state machine, adding subtract, register-to-register move and absolute jump. Undefined opcodes are handled per the power-up contract.

## Interface
- `WORD_LEN`, 64: register/ALU data width.
- `N_PUC`, 2: power-up contract width.
- `PC_WIDTH`, 32: program counter width.
- `RESET_VECTOR`, 0: PC value on reset.
- `PC_STEP`, 4: PC increment per accepted instruction.

- `clk_i` in 1: single clock, rising edge.
- `reset_ni` in 1: asynchronous, active-low reset.
- `inst_valid_i` in 1: fetch unit presents an instruction.
- `inst_ready_o` out 1: control accepts an instruction; a transfer occurs when valid and ready are both high at a rising edge.
- `inst_i` in 32: instruction word.
- `reg_rd_id_o` out reg_t: register read select. Combinational from the latched instruction.
- `reg_value_i` in WORD_LEN: combinational register-file read data for `reg_rd_id_o`.
- `alu_op_res_i` in WORD_LEN: combinational ALU result.
- `puc_i` in N_PUC: power-up contract.
- `pc_o` out PC_WIDTH: program counter to the fetch unit.
- `reg_write_en_o` out 1: register write strobe.
- `reg_id_o` out reg_t: write target.
- `reg_value_o` out WORD_LEN: write data.
- `alu_op_a_o`, `alu_op_b_o` out WORD_LEN: ALU operands.
- `alu_opc_o` out alu_op_t: ALU operation.
- `halted_o` out 1: high in HALT.
- `reset_o` out 1: system reset request. Sticky.

## Operation
- States: FETCH, DECODE, EXEC, HALT, FAULT.
- Instruction fields:
  - opcode is `inst[7:0]`, rd is `inst[15:8]`, imm16 is `inst[31:16]`, rs is `inst[23:16]`.
  - The JMP target is `{inst[31:8],2'b00}` zero-extended or truncated to PC_WIDTH.
- New opcodes OPCODE_ISUB, OPCODE_MOV and OPCODE_JMP, and ALU_OP_SUB, are defined in inst.svh and alu.svh.
- FETCH:
  - `inst_ready_o`=1.
  - On a transfer: latch `inst_i`, set `pc <= pc + PC_STEP` (mod 2^PC_WIDTH), go to DECODE.
  - Any pending `reg_write_en_o` is cleared on this edge, or on the first edge of FETCH if there is no transfer.
- DECODE, per opcode:
  - `reg_rd_id_o` = rs for MOV, else rd.
  - NOP: go to FETCH.
  - HLT: go to HALT.
  - IMOV: `reg_id_o`=rd, `reg_value_o`=zero-extended imm16, write strobe, go to FETCH.
  - MOV: `reg_id_o`=rd, `reg_value_o`=`reg_value_i`, write strobe, go to FETCH.
  - IADD/ISUB: `alu_op_a_o`=`reg_value_i`, `alu_op_b_o`=zero-extended imm16, `alu_opc_o`=ADD/SUB, `reg_id_o`=rd, go to EXEC.
  - JMP: pc <= target, go to FETCH.
  - Other opcodes: go to FAULT.
- EXEC: `reg_value_o` <= `alu_op_res_i`, write strobe, go to FETCH. Arithmetic wraps mod 2^WORD_LEN.
- FAULT:
  - If `puc_i[PUC_EOH]`=0: assert `reset_o`, which stays high until `reset_ni`, and remain in FAULT.
  - Otherwise go to HALT.
- HALT: terminal until reset. `inst_ready_o`=0 and pc is frozen.
- `inst_ready_o`=0 in every state except FETCH.
- A write strobe is high for exactly one cycle.

## Timing
- Reset values, all outputs:
  - pc=RESET_VECTOR, state FETCH, `inst_ready_o`=1.
  - `reg_write_en_o`, `reg_value_o`, `reg_id_o`, `alu_op_a_o`, `alu_op_b_o` all 0.
  - `alu_opc_o`=ALU_OP_ADD, `halted_o`=0, `reset_o`=0.
  - Latched instruction is NOP.
- Latency from the accept edge T0:
  - NOP, HLT, IMOV, MOV and JMP complete at T1. The strobe is visible in the cycle after T1, which is the next FETCH.
  - IADD/ISUB operands are latched at T1 and the strobe is visible after T2.
- Minimum spacing between accepts is 2 cycles (NOP, HLT, IMOV, MOV, JMP) or 3 cycles (IADD/ISUB).
- Back-to-back dependency: a write strobed during FETCH commits at the edge ending FETCH. The following DECODE therefore reads the new value, and no hazard stall is needed.
- `pc_o` already shows pc+PC_STEP, or the jump target, in the cycle after the edge that updates it.
- Reset asserted mid-instruction aborts immediately: no write is committed, and all outputs go to their reset values asynchronously.
- `inst_valid_i` low in FETCH stalls indefinitely with no state change.

## Test plan
- After reset, IMOV r1,#0x1234 then IMOV r2,#0xFFFF -> strobes one cycle each with (1,0x1234) and (2,0xFFFF). pc_o=8. Ready low exactly during each DECODE.
- r3=0xFFFF_FFFF_FFFF_FFFF, IADD r3,#1 -> one strobe (3,0). ISUB r3,#1 on the result -> (3,0xFFFF_FFFF_FFFF_FFFF). `alu_opc_o` is ADD then SUB.
- IMOV r4,#5 immediately followed by IADD r4,#3 -> write (4,8). Confirms no hazard.
- JMP with inst[31:8]=0x40 -> pc_o=0x100 after DECODE. Next fetch is accepted at 0x100. pc at 0xFFFF_FFFC plus a NOP wraps to 0.
- Undefined opcode 0xEE with `puc_i[PUC_EOH]`=0 -> `reset_o` high and held, ready low. With EOH=1 -> `halted_o`=1, `reset_o`=0, pc frozen.
- Pull `reset_ni` low during EXEC of IADD -> no strobe, all outputs at reset values. After release, the first instruction is fetched at RESET_VECTOR.
